hello_sched: RTL and testbench
==============================

// Module: hello_sched
// PURPOSE
//  Round-robin scheduler that shares the hello add datapath among NUM_REQ requesters.
//  Issue slots are paced at one per SLOT_PERIOD+1 cycles, the same cadence as the hello counter.
//  Each granted request returns data[3:0] + data[5:3] (mod 16), tagged with the requester id.
//  The result is held in a one-entry output register with valid/ready backpressure.
// PARAMETERS
//  NUM_REQ      4   number of requesters (>=1)
//  IDW          2   requester id width, $clog2(NUM_REQ), minimum 1
//  SLOT_PERIOD  12  cooldown reload value after each issue (5'b0_11_00)
// PORTS
//  clk_in     in   1          single clock, rising edge
//  rst        in   1          asynchronous reset, active-low
//  req_valid  in   NUM_REQ    per-requester request
//  req_data   in   6*NUM_REQ  requester i payload in [6i+5:6i]
//  req_ready  out  NUM_REQ    one-hot grant; transfer when req_valid[i] & req_ready[i]
//  res_valid  out  1          result register holds data
//  res_data   out  4          result
//  res_id     out  IDW        index of the requester that produced res_data
//  res_ready  in   1          sink accepts result when res_valid & res_ready
//  busy       out  1          state==S_COOL | res_valid
// BEHAVIOUR
//  Reset: all state clears; res_valid=0, res_data=0, res_id=0, rr_ptr=0, slot_cnt=0, state=S_OPEN.
//   busy=0 and req_ready=0 follow combinationally.
//  Reset has immediate effect mid-operation: an in-flight result is discarded and the cooldown is abandoned.
//  FSM states:
//   S_OPEN: slot_cnt==0.
//   S_COOL: slot_cnt>0; slot_cnt decrements by 1 each cycle.
//   S_COOL -> S_OPEN when slot_cnt reaches 0 (the cycle it reads 1).
//  Issue condition, combinational:
//   state==S_OPEN & |req_valid & (!res_valid | res_ready).
//   When met, req_ready has exactly one bit set: the first valid requester searching rr_ptr, rr_ptr+1, ...
//   The search wraps modulo NUM_REQ. Otherwise req_ready=0.
//   req_ready may depend combinationally on req_valid.
//  On issue (edge):
//   res_data <= {1'b0,d[3:0]} + {2'b0,d[5:3]} truncated to 4 bits.
//   res_id <= i; res_valid <= 1; slot_cnt <= SLOT_PERIOD; state <= S_COOL.
//   rr_ptr <= (i+1) mod NUM_REQ.
//  Latency: result is visible the cycle after grant. Minimum issue spacing is SLOT_PERIOD+1 cycles.
//  Output: res_valid clears on accept (res_valid & res_ready) unless a new issue occurs in the same cycle.
//   Accept plus issue in the same cycle loads the new result and keeps res_valid=1.
//   res_data and res_id are stable while res_valid & !res_ready.
//  Backpressure: while the result is unaccepted, the slot stays open and rr_ptr is frozen.
//   No request is dropped.
//  Requesters may deassert req_valid without a grant; this leaves no state behind.
//  NUM_REQ=1: rr_ptr stays 0.
//  Slot cadence is independent of requests: an idle S_OPEN waits indefinitely without penalty.
// STRUCTURE
//  hello_pkg holds SLOT_PERIOD default (5'b0_11_00), DATA_W=6, OUT_W=4, the state encodings
//   S_OPEN=1'b0 and S_COOL=1'b1, and the result function hello_sum(d).
//  One sub-module, hello_rr_pick: combinational round-robin picker.
//   Inputs: req vector, ptr. Outputs: one-hot grant, index, any.
//  Top contains the FSM, slot counter, rr_ptr and result register.
// TESTING
//  1. rst=0 with random inputs -> req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0.
//  2. Reset release, req_valid=4'b0001, data0=6'h2B -> grant on the first cycle.
//     Next cycle: res_valid=1, res_data=0 (11+5 wraps), res_id=0.
//  3. req_valid=4'hF held, res_ready=1 -> grants to ids 0,1,2,3,0 at cycles t, t+13, t+26, t+39, t+52.
//  4. data=6'h3F, res_ready=0 for 30 cycles -> exactly one grant; res_data=6, res_id stable throughout.
//     Raise res_ready -> accept and next grant in the same cycle.
//  5. Assert rst while slot_cnt=5 and res_valid=1 -> everything cleared, rr_ptr=0.
//     After release with req_valid=4'b1000 -> grant id 3 on the first cycle.
//  6. req_valid=4'b0100 pulsed only during S_COOL -> no grant.
//     req_valid=4'b0101 at slot open with rr_ptr=1 -> id 2 granted, rr_ptr becomes 3.

Source files
------------

// File: rtl/hello_pkg.sv
// Shared definitions for the hello scheduler: widths, FSM encoding and the
// add function that the shared datapath computes.
package hello_pkg;

  localparam logic [4:0] SLOT_PERIOD_DEF = 5'b0_11_00;
  localparam int         DATA_W          = 6;
  localparam int         OUT_W           = 4;

  typedef enum logic {
    S_OPEN = 1'b0,
    S_COOL = 1'b1
  } state_t;

  // d[3:0] + d[5:3], wrapped to the 4-bit result width
  function automatic logic [OUT_W-1:0] hello_sum(input logic [DATA_W-1:0] d);
    logic [OUT_W:0] s;
    s = {1'b0, d[3:0]} + {2'b0, d[5:3]};
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/hello_sched_if.sv
// Request/result bundle between requesters, the result sink and hello_sched.
interface hello_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  import hello_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic [OUT_W-1:0]          res_data;
  logic [IDW-1:0]            res_id;
  logic                      res_ready;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/hello_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr
// upward, wrapping modulo NUM_REQ.
module hello_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  // scan positions ptr, ptr+1, ... and keep the first requester found
  always_comb begin
    logic [IDW-1:0] c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    if (any) grant = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/hello_sched.sv
// Round-robin scheduler sharing the hello add datapath. One issue slot opens
// every SLOT_PERIOD+1 cycles; results sit in a one-entry valid/ready register.
module hello_sched
  import hello_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter int         IDW         = 2,
  parameter logic [4:0] SLOT_PERIOD = SLOT_PERIOD_DEF
) (
  input  logic          clk_in,
  input  logic          rst,
  hello_sched_if.slave  bus,
  output logic          busy
);

  state_t               state, state_nxt;
  logic [4:0]           slot_cnt;
  logic [IDW-1:0]       rr_ptr;
  logic                 res_valid;
  logic [OUT_W-1:0]     res_data;
  logic [IDW-1:0]       res_id;

  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;
  logic [DATA_W-1:0]    pick_data;
  logic                 issue;

  hello_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // An issue needs an open slot, a requester and room in the result register
  // (empty, or being drained this cycle). Held off while reset is asserted.
  assign issue = rst & (state == S_OPEN) & pick_any & (!res_valid | bus.res_ready);

  // payload mux for the winning requester
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) pick_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // next state: close the slot on issue, reopen when the cooldown expires
  always_comb begin
    state_nxt = state;
    case (state)
      S_OPEN: if (issue) state_nxt = (SLOT_PERIOD == 5'd0) ? S_OPEN : S_COOL;
      S_COOL: if (slot_cnt <= 5'd1) state_nxt = S_OPEN;
      default: state_nxt = S_OPEN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state <= S_OPEN;
    else      state <= state_nxt;
  end

  // cooldown counter and round-robin pointer
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      rr_ptr   <= '0;
    end else if (issue) begin
      slot_cnt <= SLOT_PERIOD;
      rr_ptr   <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end else if (state == S_COOL && slot_cnt != 5'd0) begin
      slot_cnt <= slot_cnt - 5'd1;
    end
  end

  // result register: load on issue, drop on accept, otherwise hold
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= hello_sum(pick_data);
      res_id    <= pick_idx;
    end else if (res_valid && bus.res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign bus.req_ready = issue ? grant : '0;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_id    = res_id;
  assign busy          = (state == S_COOL) | res_valid;

endmodule

// File: tb/tb_hello_sched.sv
// Randomized and directed bench for hello_sched with a cycle-level reference
// model kept in terms of "cycles since last issue" and a rotating pointer.
module tb_hello_sched;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int PER     = 12;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  logic busy;

  hello_sched_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  hello_sched #(.NUM_REQ(NUM_REQ), .IDW(IDW), .SLOT_PERIOD(5'd12)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int       m_ptr;
  bit       m_valid;
  int       m_data;
  int       m_id;
  bit       m_have;
  int       m_last;
  int       cyc = 0;
  logic [3:0] obs_rdy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_sum(input logic [5:0] d);
    int lo, hi;
    lo = int'(d) % 16;
    hi = (int'(d) / 8) % 8;
    return (lo + hi) % 16;
  endfunction

  function automatic logic [5:0] payload(input int i);
    return bus.req_data[i*6 +: 6];
  endfunction

  // Inputs already driven and settled: compare every output with the model,
  // then advance the model across the coming rising edge and wait for the
  // next falling edge.
  task automatic cycle_check(input string tag);
    bit   open;
    int   g;
    int   c;
    logic [3:0] exp_rdy;
    if (!rst) begin
      m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_have = 0;
    end
    open = !m_have || (cyc - m_last) >= PER + 1;
    g = -1;
    if (rst && open && bus.req_valid != 0 && (!m_valid || bus.res_ready)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (m_ptr + k) % NUM_REQ;
        if (g < 0 && bus.req_valid[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    obs_rdy = bus.req_ready;
    check_val({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    check_val({tag, ".res_valid"}, 32'(bus.res_valid), 32'(m_valid));
    check_val({tag, ".res_data"},  32'(bus.res_data),  32'(m_data));
    check_val({tag, ".res_id"},    32'(bus.res_id),    32'(m_id));
    check_val({tag, ".busy"},      32'(busy),          32'((!open) || m_valid));
    if (rst) begin
      if (g >= 0) begin
        m_data  = ref_sum(payload(g));
        m_id    = g;
        m_valid = 1;
        m_have  = 1;
        m_last  = cyc;
        m_ptr   = (g + 1) % NUM_REQ;
      end else if (m_valid && bus.res_ready) begin
        m_valid = 0;
      end
    end
    @(negedge clk_in);
    cyc++;
  endtask

  // run cycles with req_valid=rv until the slot is open and the result is drained
  task automatic wait_open(input string tag, input logic [3:0] rv);
    bit ok;
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      bus.req_valid = rv;
      #1;
      if (!busy) begin
        ok = 1;
        break;
      end
      check_val({tag, ".cool_no_grant"}, 32'(bus.req_ready), 32'd0);
      cycle_check(tag);
    end
    if (!ok) check_val({tag, ".open_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    bus.req_valid = 4'h0;
    #1;
    cycle_check("rst_pulse");
    rst = 1'b1;
  endtask

  int gcyc[$];
  int gid[$];
  int first_id;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    @(negedge clk_in);

    // 1: reset held with random inputs
    for (int n = 0; n < 4; n++) begin
      bus.req_valid = 4'($urandom);
      bus.req_data  = 24'($urandom);
      bus.res_ready = 1'($urandom);
      #1;
      check_val("t1.req_ready", 32'(bus.req_ready), 32'd0);
      cycle_check("t1");
    end

    // 2: first request after release is granted immediately
    rst = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data  = {18'h0, 6'h2B};
    bus.res_ready = 1'b0;
    #1;
    check_val("t2.grant", 32'(bus.req_ready), 32'h1);
    cycle_check("t2a");
    bus.req_valid = 4'b0000;
    #1;
    check_val("t2.res_valid", 32'(bus.res_valid), 32'd1);
    check_val("t2.res_data",  32'(bus.res_data),  32'd0);
    check_val("t2.res_id",    32'(bus.res_id),    32'd0);
    cycle_check("t2b");
    bus.res_ready = 1'b1;
    #1;
    cycle_check("t2c");

    // 3: all requesting, sink always ready -> 0,1,2,3,0 every 13 cycles
    pulse_reset();
    for (int n = 0; n < 70; n++) begin
      bus.req_valid = 4'hF;
      bus.req_data  = 24'($urandom);
      bus.res_ready = 1'b1;
      #1;
      if (bus.req_ready != 0) begin
        gcyc.push_back(cyc);
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gid.push_back(i);
      end
      cycle_check("t3");
    end
    check_val("t3.grant_count", 32'(gcyc.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < gid.size(); k++) begin
      check_val($sformatf("t3.id%0d", k), 32'(gid[k]), 32'(k % NUM_REQ));
      if (k > 0) check_val($sformatf("t3.gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'(PER + 1));
    end

    // 4: stalled sink -> exactly one grant, stable result, then accept+issue
    pulse_reset();
    gcyc.delete();
    bus.req_data  = {4{6'h3F}};
    bus.res_ready = 1'b0;
    for (int n = 0; n < 30; n++) begin
      bus.req_valid = 4'hF;
      #1;
      if (bus.req_ready != 0) gcyc.push_back(cyc);
      if (n > 0) begin
        check_val("t4.res_id_stable",   32'(bus.res_id),   32'd0);
        check_val("t4.res_data_stable", 32'(bus.res_data), 32'd6);
      end
      cycle_check("t4");
    end
    check_val("t4.one_grant", 32'(gcyc.size()), 32'd1);
    bus.res_ready = 1'b1;
    #1;
    check_val("t4.accept_and_grant", 32'(bus.req_ready), 32'b0010);
    cycle_check("t4b");
    check_val("t4.valid_kept", 32'(bus.res_valid), 32'd1);
    check_val("t4.new_id",     32'(bus.res_id),    32'd1);

    // 5: reset mid-cooldown with a pending result
    pulse_reset();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    cycle_check("t5a");
    for (int n = 0; n < 7; n++) begin
      bus.req_valid = 4'b0000;
      #1;
      cycle_check("t5b");
    end
    rst = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    check_val("t5.rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("t5.rst_busy",      32'(busy),          32'd0);
    check_val("t5.rst_req_ready", 32'(bus.req_ready), 32'd0);
    cycle_check("t5c");
    rst = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    check_val("t5.grant3", 32'(bus.req_ready), 32'b1000);
    cycle_check("t5d");

    // 6: requests only during cooldown leave nothing behind; pointer rotation
    bus.res_ready = 1'b1;
    wait_open("t6a", 4'b0100);
    bus.req_valid = 4'b0001;
    #1;
    check_val("t6.grant0", 32'(bus.req_ready), 32'b0001);
    cycle_check("t6b");
    wait_open("t6c", 4'b0000);
    bus.req_valid = 4'b0101;
    #1;
    check_val("t6.grant2", 32'(bus.req_ready), 32'b0100);
    cycle_check("t6d");
    wait_open("t6e", 4'b0000);
    bus.req_valid = 4'hF;
    #1;
    check_val("t6.ptr3", 32'(bus.req_ready), 32'b1000);
    cycle_check("t6f");

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      bus.req_valid = 4'($urandom);
      if ($urandom_range(0, 2) == 0) bus.req_valid = 4'h0;
      bus.req_data  = 24'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 99) != 0);
      #1;
      cycle_check("rnd");
    end
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
